pulse_stretcher: RTL

Converts single-cycle event pulses (from the stopwatch's button edge detectors and control FSM) back into a timed level: each accepted trigger drives `level_out` high for a programmable number of time units, then low for a fixed guard gap. It feeds the indicator LED and buzzer outputs. Supports retriggering, a one-deep pending trigger, and cancel.

---
 rtl/pulse_stretcher_if.sv | 23 ++
 rtl/pulse_stretcher.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pulse_stretcher_if.sv
// Bundle of the pulse stretcher request inputs and level/status outputs.
// The master side issues trigger/duration/cancel; the slave side (the
// stretcher itself) returns the stretched level and status flags.
interface pulse_stretcher_if #(
  parameter int WIDTH = 8
) ();
  logic             trigger;
  logic [WIDTH-1:0] duration;
  logic             cancel;
  logic             level_out;
  logic             busy;
  logic             done;

  modport master (
    output trigger, duration, cancel,
    input  level_out, busy, done
  );

  modport slave (
    input  trigger, duration, cancel,
    output level_out, busy, done
  );
endinterface

// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns single-cycle trigger pulses into a level held high
// for `duration` time units (PRESCALE clocks each), followed by an optional
// low guard gap of GAP units. Supports retrigger or a one-deep pending queue,
// and a cancel that aborts everything immediately.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | nothing running, level low
// S_ACTIVE | level high, unit counter counting down the active period
// S_GAP    | level forced low, unit counter counting down the guard gap
module pulse_stretcher #(
  parameter int PRESCALE  = 50000,
  parameter int WIDTH     = 8,
  parameter int GAP       = 2,
  parameter bit RETRIGGER = 1'b1
) (
  input logic              clk,
  input logic              reset,
  pulse_stretcher_if.slave ps
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  // The unit counter is shared between the active period and the gap, so it
  // has to hold whichever of the two is wider.
  localparam int CW = (WIDTH > GW) ? WIDTH : GW;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] pend_dur_q, pend_dur_d;
  logic             level_q, level_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             trig_ok;
  logic             pend_hit;
  logic             pend_any;
  logic [WIDTH-1:0] pend_dur_eff;
  logic             presc_wrap;
  logic             last_unit;

  // Next-state, counter and registered-output computation.
  always_comb begin
    trig_ok  = ps.trigger && (ps.duration != '0);
    // A trigger that cannot restart the period is queued; it is folded in
    // this cycle so a trigger landing on the very last gap/active cycle is
    // not lost.
    pend_hit = trig_ok && ((state_q == S_GAP) ||
                           ((state_q == S_ACTIVE) && !RETRIGGER));
    pend_any     = pend_q || pend_hit;
    pend_dur_eff = pend_hit ? ps.duration : pend_dur_q;
    presc_wrap   = (presc_q == PW'(PRESCALE - 1));
    last_unit    = presc_wrap && (cnt_q == CW'(1));

    state_d    = state_q;
    presc_d    = presc_q;
    cnt_d      = cnt_q;
    pend_d     = pend_any;
    pend_dur_d = pend_dur_eff;
    done_d     = 1'b0;

    if (ps.cancel) begin
      state_d    = S_IDLE;
      presc_d    = '0;
      cnt_d      = '0;
      pend_d     = 1'b0;
      pend_dur_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (trig_ok) begin
            state_d = S_ACTIVE;
            presc_d = '0;
            cnt_d   = CW'(ps.duration);
          end
        end

        S_ACTIVE: begin
          if (trig_ok && RETRIGGER) begin
            presc_d = '0;
            cnt_d   = CW'(ps.duration);
          end else begin
            presc_d = presc_wrap ? '0 : presc_q + PW'(1);
            if (presc_wrap) begin
              cnt_d = cnt_q - CW'(1);
            end
            if (last_unit) begin
              done_d = 1'b1;
              if (GAP > 0) begin
                state_d = S_GAP;
                cnt_d   = CW'(GAP);
              end else if (pend_any) begin
                cnt_d  = CW'(pend_dur_eff);
                pend_d = 1'b0;
              end else begin
                state_d = S_IDLE;
              end
            end
          end
        end

        S_GAP: begin
          presc_d = presc_wrap ? '0 : presc_q + PW'(1);
          if (presc_wrap) begin
            cnt_d = cnt_q - CW'(1);
          end
          if (last_unit) begin
            if (pend_any) begin
              state_d = S_ACTIVE;
              cnt_d   = CW'(pend_dur_eff);
              pend_d  = 1'b0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end

        default: begin
          state_d    = S_IDLE;
          presc_d    = '0;
          cnt_d      = '0;
          pend_d     = 1'b0;
          pend_dur_d = '0;
        end
      endcase
    end

    level_d = (state_d == S_ACTIVE);
    busy_d  = (state_d != S_IDLE) || pend_d;
  end

  // State, counters, pending queue and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      pend_dur_q <= '0;
      level_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_dur_q <= pend_dur_d;
      level_q    <= level_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign ps.level_out = level_q;
  assign ps.busy      = busy_q;
  assign ps.done      = done_q;

endmodule
